// File: rtl/imem_loader.sv
// Boot loader: takes a framed byte stream (SYNC, N lo/hi, N little-endian words, XOR checksum),
// writes the words to instruction memory and releases the core only after a good checksum.
module imem_loader #(
  parameter int          ADDR_W      = 8,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int          TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code,
  output logic [15:0]       words_loaded
);

  localparam int             TW     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [16:0]    MAX_N  = 17'(2 ** ADDR_W);

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CHECK, RUN, ERR} state_t;

  // Handshake: a byte transfers on a rising edge where rx_valid & rx_ready;
  // rx_ready is 0 only while reset is asserted, so the loader never backpressures.
  state_t        state;
  logic [15:0]   nlen;
  logic [7:0]    csum;
  logic [23:0]   wbuf;
  logic [1:0]    bidx;
  logic [TW-1:0] tcnt;
  logic          accept;

  assign accept = rx_valid & rx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rx_ready     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_rst_n   <= 1'b0;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      err_code     <= 2'b00;
      words_loaded <= '0;
      nlen         <= '0;
      csum         <= '0;
      wbuf         <= '0;
      bidx         <= '0;
      tcnt         <= '0;
    end else begin
      rx_ready <= 1'b1;
      imem_we  <= 1'b0;
      case (state)
        LEN_LO, LEN_HI, DATA, CHECK: begin
          if (accept) begin
            tcnt <= '0;
            csum <= csum ^ rx_data;
            case (state)
              LEN_LO: begin
                nlen[7:0] <= rx_data;
                state     <= LEN_HI;
              end
              LEN_HI: begin
                nlen[15:8] <= rx_data;
                if ({1'b0, rx_data, nlen[7:0]} > MAX_N) begin
                  state    <= ERR;
                  err_code <= 2'b01;
                  load_err <= 1'b1;
                end else if ({rx_data, nlen[7:0]} == 16'd0) begin
                  state <= CHECK;
                end else begin
                  state <= DATA;
                end
              end
              DATA: begin
                bidx <= bidx + 2'd1;
                if (bidx == 2'd3) begin
                  // wbuf holds {b2,b1,b0}; the incoming byte is b3
                  imem_we      <= 1'b1;
                  imem_addr    <= words_loaded[ADDR_W-1:0];
                  imem_wdata   <= {rx_data, wbuf};
                  words_loaded <= words_loaded + 16'd1;
                  if (words_loaded + 16'd1 == nlen) state <= CHECK;
                end else begin
                  wbuf <= {rx_data, wbuf[23:8]};
                end
              end
              default: begin
                if (rx_data == csum) begin
                  state      <= RUN;
                  load_done  <= 1'b1;
                  core_rst_n <= 1'b1;
                end else begin
                  state    <= ERR;
                  err_code <= 2'b10;
                  load_err <= 1'b1;
                end
              end
            endcase
          end else if (tcnt == T_LAST) begin
            state    <= ERR;
            err_code <= 2'b11;
            load_err <= 1'b1;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        default: begin
          // IDLE, RUN and ERR only react to a frame start; other bytes are dropped
          if (accept && rx_data == SYNC_BYTE) begin
            state        <= LEN_LO;
            csum         <= '0;
            words_loaded <= '0;
            err_code     <= 2'b00;
            bidx         <= '0;
            tcnt         <= '0;
            core_rst_n   <= 1'b0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: framed byte stimulus, a write scoreboard (address, data, cycle)
// and per-scenario status checks.
module tb_imem_loader;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              load_done;
  logic              load_err;
  logic [1:0]        err_code;
  logic [15:0]       words_loaded;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [39:0] exp_q[$];
  int          exp_cyc_q[$];
  logic [31:0] fw [0:255];
  logic [39:0] mon_e;
  int          mon_c;

  imem_loader #(.ADDR_W(ADDR_W), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst_n(core_rst_n),
    .load_done(load_done), .load_err(load_err), .err_code(err_code), .words_loaded(words_loaded)
  );

  // clock / reset-time bookkeeping
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard: every write strobe must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && imem_we) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: got addr=%0h data=%h, expected no write", imem_addr, imem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        mon_c = exp_cyc_q.pop_front();
        if ({imem_addr, imem_wdata} !== mon_e || cyc !== mon_c) begin
          errors++;
          $display("FAIL imem_write: got addr=%0h data=%h cyc=%0d, expected addr=%0h data=%h cyc=%0d",
                   imem_addr, imem_wdata, cyc, mon_e[39:32], mon_e[31:0], mon_c);
        end
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] csum_flip, input int max_gap);
    logic [7:0] cs;
    logic [7:0] b;
    cs = n[7:0] ^ n[15:8];
    send_byte(8'hA5);
    send_byte(n[7:0]);
    send_byte(n[15:8]);
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        b  = fw[i][8*j +: 8];
        cs = cs ^ b;
        if (max_gap > 0) idle($urandom_range(0, max_gap));
        send_byte(b);
        if (j == 3) begin
          exp_q.push_back({i[ADDR_W-1:0], fw[i]});
          exp_cyc_q.push_back(cyc + 1);
        end
      end
    end
    send_byte(cs ^ csum_flip);
    idle(3);
  endtask

  // scenarios
  task automatic test_reset();
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, load_done, load_err, err_code, core_rst_n, words_loaded} !== '0) begin
      errors++;
      $display("FAIL reset_values: got rdy=%b we=%b addr=%0h wd=%h done=%b err=%b code=%b crst=%b wl=%0d, expected all 0",
               rx_ready, imem_we, imem_addr, imem_wdata, load_done, load_err, err_code, core_rst_n, words_loaded);
    end
    rx_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL rx_ready_after_reset: got %b, expected 1", rx_ready);
    end
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'hFF);
    idle(3);
    checks++;
    if ({load_done, load_err, err_code, core_rst_n, words_loaded} !== 21'd0) begin
      errors++;
      $display("FAIL junk_in_idle: got done=%b err=%b code=%b crst=%b wl=%0d, expected idle",
               load_done, load_err, err_code, core_rst_n, words_loaded);
    end
  endtask

  task automatic test_single_word();
    fw[0] = 32'h0000_0013;
    send_frame(1, 8'h00, 0);
    checks++;
    if ({load_done, load_err, err_code, core_rst_n, words_loaded} !== {1'b1, 1'b0, 2'b00, 1'b1, 16'd1}) begin
      errors++;
      $display("FAIL single_word_status: got done=%b err=%b code=%b crst=%b wl=%0d, expected 1 0 00 1 1",
               load_done, load_err, err_code, core_rst_n, words_loaded);
    end
  endtask

  task automatic test_bad_checksum();
    fw[0] = 32'h0000_0013;
    send_frame(1, 8'h01, 0);
    idle(10);
    checks++;
    if ({load_done, load_err, err_code, core_rst_n, words_loaded} !== {1'b0, 1'b1, 2'b10, 1'b0, 16'd1}) begin
      errors++;
      $display("FAIL bad_checksum_status: got done=%b err=%b code=%b crst=%b wl=%0d, expected 0 1 10 0 1",
               load_done, load_err, err_code, core_rst_n, words_loaded);
    end
  endtask

  task automatic test_overflow();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h01);
    idle(1);
    checks++;
    if ({load_done, load_err, err_code, core_rst_n, words_loaded} !== {1'b0, 1'b1, 2'b01, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL overflow_status: got done=%b err=%b code=%b crst=%b wl=%0d, expected 0 1 01 0 0",
               load_done, load_err, err_code, core_rst_n, words_loaded);
    end
    send_byte(8'h13);
    idle(20);
    checks++;
    if ({load_err, err_code} !== {1'b1, 2'b01}) begin
      errors++;
      $display("FAIL overflow_hold: got err=%b code=%b, expected 1 01", load_err, err_code);
    end
  endtask

  task automatic test_zero_len();
    send_frame(0, 8'h00, 0);
    checks++;
    if ({load_done, load_err, err_code, core_rst_n, words_loaded} !== {1'b1, 1'b0, 2'b00, 1'b1, 16'd0}) begin
      errors++;
      $display("FAIL zero_len_status: got done=%b err=%b code=%b crst=%b wl=%0d, expected 1 0 00 1 0",
               load_done, load_err, err_code, core_rst_n, words_loaded);
    end
  endtask

  task automatic test_back_to_back();
    fw[0] = 32'hA5A5_A5A5;
    fw[1] = 32'h1234_5678;
    fw[2] = 32'hDEAD_BEEF;
    send_frame(3, 8'h00, 0);
    checks++;
    if ({load_done, load_err, err_code, core_rst_n, words_loaded} !== {1'b1, 1'b0, 2'b00, 1'b1, 16'd3}) begin
      errors++;
      $display("FAIL back_to_back_status: got done=%b err=%b code=%b crst=%b wl=%0d, expected 1 0 00 1 3",
               load_done, load_err, err_code, core_rst_n, words_loaded);
    end
  endtask

  task automatic test_max_len();
    for (int i = 0; i < 256; i++) fw[i] = $urandom;
    send_frame(256, 8'h00, 0);
    checks++;
    if ({load_done, load_err, err_code, core_rst_n, words_loaded} !== {1'b1, 1'b0, 2'b00, 1'b1, 16'd256}) begin
      errors++;
      $display("FAIL max_len_status: got done=%b err=%b code=%b crst=%b wl=%0d, expected 1 0 00 1 256",
               load_done, load_err, err_code, core_rst_n, words_loaded);
    end
  endtask

  task automatic test_timeout();
    send_byte(8'hA5);
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    idle(10);
    checks++;
    if ({load_done, load_err, err_code, core_rst_n, words_loaded} !== 21'd0) begin
      errors++;
      $display("FAIL timeout_early: got done=%b err=%b code=%b crst=%b wl=%0d, expected still loading",
               load_done, load_err, err_code, core_rst_n, words_loaded);
    end
    idle(10);
    checks++;
    if ({load_done, load_err, err_code, core_rst_n, words_loaded} !== {1'b0, 1'b1, 2'b11, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL timeout_status: got done=%b err=%b code=%b crst=%b wl=%0d, expected 0 1 11 0 0",
               load_done, load_err, err_code, core_rst_n, words_loaded);
    end
    fw[0] = 32'hCAFE_0001;
    fw[1] = 32'h0BAD_F00D;
    send_frame(2, 8'h00, 3);
    checks++;
    if ({load_done, load_err, err_code, core_rst_n, words_loaded} !== {1'b1, 1'b0, 2'b00, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL timeout_recover: got done=%b err=%b code=%b crst=%b wl=%0d, expected 1 0 00 1 2",
               load_done, load_err, err_code, core_rst_n, words_loaded);
    end
  endtask

  task automatic test_reset_mid_data();
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h13);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    // reset lands right after the 4th data byte, while its write strobe is up
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rx_valid = 1'b0;
    #1;
    checks++;
    if ({rx_ready, imem_we, imem_addr, imem_wdata, load_done, load_err, err_code, core_rst_n, words_loaded} !== '0) begin
      errors++;
      $display("FAIL reset_mid_data: got rdy=%b we=%b addr=%0h wd=%h done=%b err=%b code=%b crst=%b wl=%0d, expected all 0",
               rx_ready, imem_we, imem_addr, imem_wdata, load_done, load_err, err_code, core_rst_n, words_loaded);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_byte(8'h00);
    send_byte(8'hFF);
    idle(2);
    fw[0] = 32'h0000_0013;
    fw[1] = 32'h00A0_0093;
    send_frame(2, 8'h00, 1);
    checks++;
    if ({load_done, load_err, err_code, core_rst_n, words_loaded} !== {1'b1, 1'b0, 2'b00, 1'b1, 16'd2}) begin
      errors++;
      $display("FAIL reset_recover: got done=%b err=%b code=%b crst=%b wl=%0d, expected 1 0 00 1 2",
               load_done, load_err, err_code, core_rst_n, words_loaded);
    end
  endtask

  task automatic test_random();
    int n;
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) fw[i] = $urandom;
      send_frame(n, 8'h00, 3);
      checks++;
      if ({load_done, load_err, err_code, core_rst_n, words_loaded} !== {1'b1, 1'b0, 2'b00, 1'b1, 16'(n)}) begin
        errors++;
        $display("FAIL random_frame_%0d: got done=%b err=%b code=%b crst=%b wl=%0d, expected 1 0 00 1 %0d",
                 k, load_done, load_err, err_code, core_rst_n, words_loaded, n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_bad_checksum();
    test_overflow();
    test_zero_len();
    test_back_to_back();
    test_max_len();
    test_timeout();
    test_reset_mid_data();
    test_random();
    idle(5);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL pending_writes: got %0d outstanding expected writes, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
